// File: rtl/npu_pkg.sv
// Shared types and register-map constants for the NPU accelerator control block.
package npu_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StRun   = 2'd2,
        StAbort = 2'd3
    } npu_state_e;

    // Register index, taken from addr[25:24]
    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegStart  = 2'd1;
    localparam logic [1:0] RegCycles = 2'd2;
    localparam logic [1:0] RegStatus = 2'd3;

    localparam int unsigned CtrlRunBit  = 0;
    localparam int unsigned CtrlStopBit = 1;
    localparam int unsigned CtrlAddrLsb = 16;

    localparam int unsigned StatBusyBit  = 0;
    localparam int unsigned StatAbortBit = 1;
    localparam int unsigned StatErrBit   = 2;
    localparam int unsigned StatStateLsb = 4;

endpackage

// File: rtl/npu_bus_slave_if.sv
// Valid/ready register-slave front end: one-cycle ack pulse, registered read data from a
// four-entry read mux, and a write command presented to the register block in the ack cycle.
module npu_bus_slave_if (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       wstrb_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o,
    input  logic [3:0][31:0] rd_regs_i,
    output logic             wr_en_o,
    output logic [1:0]       wr_sel_o,
    output logic [3:0]       wr_strb_o,
    output logic [31:0]      wr_data_o
);

    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wr_en_q, wr_en_d;
    logic [1:0]  wr_sel_q, wr_sel_d;
    logic [3:0]  wr_strb_q, wr_strb_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        accept;
    logic [1:0]  sel;
    logic        unused_addr;

    assign sel         = addr_i[25:24];
    // A held valid is only re-accepted after ready has dropped for one cycle
    assign accept      = valid_i && !ready_q;
    assign unused_addr = ^{addr_i[31:26], addr_i[23:0]};

    always_comb begin
        ready_d   = accept;
        rdata_d   = '0;
        wr_en_d   = accept && (wstrb_i != 4'b0000);
        wr_sel_d  = wr_sel_q;
        wr_strb_d = wr_strb_q;
        wr_data_d = wr_data_q;
        if (accept) begin
            wr_sel_d  = sel;
            wr_strb_d = wstrb_i;
            wr_data_d = wdata_i;
            if (wstrb_i == 4'b0000) begin
                rdata_d = rd_regs_i[sel];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_strb_q <= '0;
            wr_data_q <= '0;
        end else begin
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_strb_q <= wr_strb_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign ready_o   = ready_q;
    assign rdata_o   = rdata_q;
    assign wr_en_o   = wr_en_q;
    assign wr_sel_o  = wr_sel_q;
    assign wr_strb_o = wr_strb_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: rtl/npu_acc_ctrl.sv
// Control/status register block for the NPU accelerator: turns host CTRL writes into
// start/abort pulses for the core and exposes start address, run cycles and status.
module npu_acc_ctrl
    import npu_pkg::*;
#(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned ABORT_TIMEOUT = 1024
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        wstrb_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              core_start_o,
    output logic [ADDR_W-1:0] core_start_addr_o,
    output logic              core_abort_o,
    input  logic              core_done_i
);

    localparam int unsigned TmoW = (ABORT_TIMEOUT > 1) ? $clog2(ABORT_TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(ABORT_TIMEOUT - 1);

    npu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              start_q, start_d;
    logic              abort_q, abort_d;

    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [3:0]        wr_strb;
    logic [31:0]       wr_data;
    logic [3:0][31:0]  rd_regs;
    logic              ctrl_wr, run_cmd, stop_cmd, busy, aborting;
    logic [15:0]       addr16, addr16_wr;
    logic              unused_wr;

    npu_bus_slave_if u_bus (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .wstrb_i   (wstrb_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .rd_regs_i (rd_regs),
        .wr_en_o   (wr_en),
        .wr_sel_o  (wr_sel),
        .wr_strb_o (wr_strb),
        .wr_data_o (wr_data)
    );

    assign unused_wr = ^{wr_data[15:2], wr_strb[1]};
    assign busy      = (state_q != StIdle);
    assign aborting  = (state_q == StAbort);
    assign addr16    = 16'(start_addr_q);

    // STOP wins over RUN in the same write
    assign ctrl_wr  = wr_en && (wr_sel == RegCtrl);
    assign stop_cmd = ctrl_wr && wr_strb[0] && wr_data[CtrlStopBit];
    assign run_cmd  = ctrl_wr && wr_strb[0] && wr_data[CtrlRunBit] && !wr_data[CtrlStopBit];

    always_comb begin
        addr16_wr = addr16;
        if (wr_strb[2]) addr16_wr[7:0]  = wr_data[CtrlAddrLsb +: 8];
        if (wr_strb[3]) addr16_wr[15:8] = wr_data[CtrlAddrLsb + 8 +: 8];
    end

    always_comb begin
        rd_regs                        = '0;
        rd_regs[RegCtrl]               = {addr16, 14'd0, aborting, busy};
        rd_regs[RegStart]              = 32'(start_addr_q);
        rd_regs[RegCycles]             = 32'(cyc_q);
        rd_regs[RegStatus][StatBusyBit]  = busy;
        rd_regs[RegStatus][StatAbortBit] = aborting;
        rd_regs[RegStatus][StatErrBit]   = err_q;
        rd_regs[RegStatus][StatStateLsb +: 4] = {2'b00, state_q};
    end

    always_comb begin
        state_d      = state_q;
        start_addr_d = start_addr_q;
        cyc_d        = cyc_q;
        tmo_d        = tmo_q;
        err_d        = err_q;
        start_d      = 1'b0;
        abort_d      = 1'b0;

        // Address is frozen while a job is in flight
        if (ctrl_wr && state_q == StIdle) begin
            start_addr_d = ADDR_W'(addr16_wr);
        end
        if (run_cmd && state_q != StIdle) begin
            err_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (run_cmd) begin
                    state_d = StStart;
                    cyc_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StStart: begin
                state_d = StRun;
                start_d = 1'b1;
            end
            StRun: begin
                if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
                if (core_done_i) begin
                    state_d = StIdle;
                end else if (stop_cmd) begin
                    state_d = StAbort;
                    abort_d = 1'b1;
                    tmo_d   = '0;
                end
            end
            StAbort: begin
                tmo_d = tmo_q + TmoW'(1);
                if (core_done_i || tmo_q == TmoLast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            start_addr_q <= '0;
            cyc_q        <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            start_q      <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_addr_q <= start_addr_d;
            cyc_q        <= cyc_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            start_q      <= start_d;
            abort_q      <= abort_d;
        end
    end

    assign core_start_o      = start_q;
    assign core_abort_o      = abort_q;
    assign core_start_addr_o = start_addr_q;

endmodule

// File: tb/tb_npu_acc_ctrl.sv
// Self-checking bench for npu_acc_ctrl: directed scenarios plus randomized jobs, all checked
// against a transaction-level model of the register map and job timing.
module tb_npu_acc_ctrl;
    import npu_pkg::*;

    localparam int Tmo = 1024;

    logic        clock = 1'b0;
    logic        reset, valid, core_done;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata, rdata;
    logic        ready, core_start, core_abort;
    logic [15:0] core_start_addr;

    int cyc = 0;
    int done_at = -1;
    int n_checks = 0, n_errors = 0;
    int start_cnt = 0, start_cyc = -1, abort_cnt = 0, abort_cyc = -1;
    int e_start = 0, e_abort = 0;

    // Reference model: spec-level job state
    logic [15:0] m_addr = '0;
    logic        m_err = 1'b0;
    int          m_state = 0;
    int          m_cycles = 0;

    npu_acc_ctrl #(
        .ADDR_W        (16),
        .CNT_W         (32),
        .ABORT_TIMEOUT (Tmo)
    ) dut (
        .clock_i           (clock),
        .reset_i           (reset),
        .valid_i           (valid),
        .ready_o           (ready),
        .wstrb_i           (wstrb),
        .addr_i            (addr),
        .wdata_i           (wdata),
        .rdata_o           (rdata),
        .core_start_o      (core_start),
        .core_start_addr_o (core_start_addr),
        .core_abort_o      (core_abort),
        .core_done_i       (core_done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (core_start) begin start_cnt++; start_cyc = cyc; end
        if (core_abort) begin abort_cnt++; abort_cyc = cyc; end
    end

    initial begin
        core_done = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            core_done = (cyc == done_at);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin @(posedge clock); #1; end
    endtask

    task automatic bus(input int at, input logic [1:0] sel, input logic [3:0] strb,
                       input logic [31:0] data, output logic [31:0] rd, output int ack);
        int   acc;
        logic got;
        wait_to(at);
        acc = cyc; got = 1'b0; rd = '0; ack = -1;
        valid = 1'b1; addr = {6'd0, sel, 24'd0}; wstrb = strb; wdata = data;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clock); #1;
            if (ready) begin got = 1'b1; ack = cyc; rd = rdata; end
        end
        valid = 1'b0; wstrb = '0; wdata = '0;
        check_eq("bus_ack", {31'd0, got}, 32'd1);
        if (got) check_eq("ack_latency", ack - acc, 1);
    endtask

    task automatic rd_reg(input logic [1:0] sel, output logic [31:0] v);
        int a;
        bus(cyc + 1, sel, 4'h0, 32'h0, v, a);
    endtask

    task automatic wr_reg(input logic [1:0] sel, input logic [3:0] s, input logic [31:0] d,
                          output int a);
        logic [31:0] v;
        bus(cyc + 1, sel, s, d, v, a);
    endtask

    function automatic logic [15:0] upd_addr(input logic [15:0] a, input logic [3:0] s,
                                             input logic [31:0] d);
        upd_addr = a;
        if (s[2]) upd_addr[7:0]  = d[23:16];
        if (s[3]) upd_addr[15:8] = d[31:24];
    endfunction

    function automatic logic [31:0] exp_status();
        return {24'd0, 4'(m_state), 1'b0, m_err, (m_state == 3), (m_state != 0)};
    endfunction

    task automatic chk_status(input string tag);
        logic [31:0] v;
        rd_reg(RegStatus, v);
        check_eq(tag, v, exp_status());
    endtask

    task automatic chk_regs();
        logic [31:0] v;
        rd_reg(RegCycles, v);
        check_eq("cycles_reg", v, m_cycles);
        rd_reg(RegStart, v);
        check_eq("start_reg", v, {16'd0, m_addr});
        rd_reg(RegCtrl, v);
        check_eq("ctrl_reg", v, {m_addr, 14'd0, (m_state == 3), (m_state != 0)});
    endtask

    task automatic do_stop(input int s, output int r2);
        wr_reg(RegCtrl, 4'h1, 32'h0000_0002, r2);
        m_cycles = r2 - s + 1; e_abort++; m_state = 3;
        wait_to(r2 + 2);
        check_eq("abort_cnt", abort_cnt, e_abort);
        check_eq("abort_time", abort_cyc, r2 + 1);
    endtask

    // mode: 0 done, 1 stop then done, 2 stop colliding with done, 3 stop then timeout
    task automatic job(input logic [3:0] rs, input logic [31:0] up, input bit busy_run,
                       input int mode, input int len);
        int          r, s, d, r2;
        logic [31:0] v, bd;
        wr_reg(RegCtrl, rs, {up[31:16], 16'h0001}, r);
        m_addr = upd_addr(m_addr, rs, up);
        m_err = 1'b0; m_cycles = 0; e_start++;
        wait_to(r + 3);
        check_eq("start_cnt", start_cnt, e_start);
        check_eq("start_time", start_cyc, r + 2);
        check_eq("start_addr_out", {16'd0, core_start_addr}, {16'd0, m_addr});
        s = r + 2; m_state = 2;
        if (busy_run) begin
            bd = $urandom; bd[1:0] = 2'b01;
            wr_reg(RegCtrl, 4'hF, bd, r2);
            m_err = 1'b1;
            wait_to(r2 + 1);
            check_eq("busy_run_addr", {16'd0, core_start_addr}, {16'd0, m_addr});
        end
        chk_status("status_run");
        case (mode)
            0: begin
                d = s + len - 1;
                if (d <= cyc) d = cyc + 1;
                done_at = d;
                wait_to(d + 1);
                m_cycles = d - s + 1; m_state = 0;
            end
            1: begin
                do_stop(s, r2);
                chk_status("status_abort");
                chk_regs();
                d = cyc + 1 + int'($urandom % 20);
                done_at = d;
                wait_to(d + 1);
                m_state = 0;
            end
            2: begin
                d = cyc + 2;
                done_at = d;
                bus(d - 1, RegCtrl, 4'h1, 32'h0000_0002, v, r2);
                m_cycles = r2 - s + 1; m_state = 0;
                wait_to(r2 + 3);
                check_eq("no_abort_on_done", abort_cnt, e_abort);
            end
            default: begin
                do_stop(s, r2);
                bus(r2 + Tmo + len, RegStatus, 4'h0, 32'h0, v, r);
                m_state = (len == 0) ? 3 : 0;
                check_eq("status_tmo_edge", v, exp_status());
                wait_to(r2 + Tmo + 3);
                m_state = 0;
            end
        endcase
        done_at = -1;
        chk_status("status_end");
        chk_regs();
    endtask

    initial begin
        int          r;
        logic [31:0] v, dt;
        logic [3:0]  st;
        logic [4:0]  pat;

        reset = 1'b1; valid = 1'b0; wstrb = '0; addr = '0; wdata = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        check_eq("rst_outputs", {29'd0, ready, core_start, core_abort}, 32'd0);
        check_eq("rst_addr", {16'd0, core_start_addr}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        rd_reg(RegStatus, v);
        check_eq("rst_status", v, 32'd0);
        chk_regs();

        // Basic job, done after 50 run cycles
        job(4'hF, 32'h1234_0000, 1'b0, 0, 50);
        rd_reg(RegCycles, v);
        check_eq("cycles_50", v, 32'd50);
        check_eq("addr_1234", {16'd0, core_start_addr}, 32'h0000_1234);

        // Abort paths: ack by done, then timeout on both sides of the boundary
        job(4'h1, 32'h0, 1'b0, 1, 0);
        job(4'h1, 32'h0, 1'b0, 3, 0);
        job(4'h1, 32'h0, 1'b0, 3, 1);

        // RUN+STOP in IDLE is a no-op for the FSM; address bytes still update
        wr_reg(RegCtrl, 4'hF, 32'h5678_0003, r);
        m_addr = upd_addr(m_addr, 4'hF, 32'h5678_0003);
        wait_to(r + 4);
        check_eq("runstop_no_start", start_cnt, e_start);
        chk_status("runstop_status");
        check_eq("runstop_addr", {16'd0, core_start_addr}, 32'h0000_5678);

        // RUN while busy sets sticky error
        job(4'h1, 32'h0, 1'b1, 0, 20);
        rd_reg(RegStatus, v);
        check_eq("err_sticky", v, 32'h0000_0004);

        // Writes to read-only registers are acked and ignored
        wr_reg(RegStatus, 4'hF, 32'hFFFF_FFFF, r);
        wr_reg(RegStart, 4'hF, 32'hFFFF_FFFF, r);
        wait_to(r + 4);
        check_eq("ro_no_start", start_cnt, e_start);
        chk_status("ro_status");
        chk_regs();

        // Reset mid-job
        wr_reg(RegCtrl, 4'hF, 32'h4321_0001, r);
        e_start++;
        wait_to(r + 6);
        reset = 1'b1;
        @(posedge clock); #1;
        check_eq("midrst_outputs", {29'd0, ready, core_start, core_abort}, 32'd0);
        check_eq("midrst_addr", {16'd0, core_start_addr}, 32'd0);
        check_eq("midrst_rdata", rdata, 32'd0);
        reset = 1'b0;
        m_state = 0; m_addr = '0; m_err = 1'b0; m_cycles = 0;
        wait_to(cyc + 4);
        check_eq("midrst_no_abort", abort_cnt, e_abort);
        chk_status("midrst_status");
        chk_regs();

        // Byte-enabled address write, then RUN without address bytes
        wr_reg(RegCtrl, 4'b0100, 32'h00AB_0000, r);
        m_addr = upd_addr(m_addr, 4'b0100, 32'h00AB_0000);
        job(4'b0001, 32'hFFFF_0000, 1'b0, 0, 20);
        check_eq("addr_00ab", {16'd0, core_start_addr}, 32'h0000_00AB);

        // Held valid: two ack pulses separated by one low cycle
        wait_to(cyc + 1);
        valid = 1'b1; addr = {6'd0, RegStatus, 24'd0}; wstrb = 4'h0;
        pat = '0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock); #1;
            if (k == 4) valid = 1'b0;
            pat[k-1] = ready;
        end
        check_eq("hold_valid_pulses", {27'd0, pat}, 32'h0000_0005);

        // Randomized jobs
        for (int i = 0; i < 14; i++) begin
            if ($urandom % 2 == 0) begin
                st = 4'($urandom); dt = $urandom; dt[0] = 1'b0;
                wr_reg(RegCtrl, st, dt, r);
                m_addr = upd_addr(m_addr, st, dt);
            end
            if ($urandom % 3 == 0) begin
                r = cyc + 2;
                done_at = r;
                wait_to(r + 2);
                done_at = -1;
                check_eq("idle_done_ignored", start_cnt, e_start);
                chk_status("idle_done_status");
            end
            st = 4'($urandom); st[0] = 1'b1;
            job(st, $urandom, 1'($urandom % 2), int'($urandom % 3), 12 + int'($urandom % 40));
        end

        check_eq("final_start_cnt", start_cnt, e_start);
        check_eq("final_abort_cnt", abort_cnt, e_abort);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
